// File: rtl/clkdiv_bank.sv
// Bank of NCH independent programmable clock-enable dividers sharing one clock.
// Each channel runs a wrap counter with a shadowed limit and a square or pulse output.
module clkdiv_ch #(
  parameter int                BITLEN  = 8,
  parameter logic [BITLEN-1:0] RST_LIM = {BITLEN{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [BITLEN-1:0] i_lim,
  input  logic              i_load,
  input  logic              i_sync,
  output logic              o_tick,
  output logic              o_hz,
  output logic              o_pend
);
  logic [BITLEN-1:0] r_ctr, r_lim_act, r_lim_shd;
  logic              r_pend, r_tick, r_hz;
  logic              w_wrap, w_apply;

  assign w_wrap  = i_en & ~i_sync & (r_ctr == r_lim_act);
  // Shadow goes live at a wrap, while idle, or on sync so a period is never cut short.
  assign w_apply = r_pend & (i_sync | ~i_en | w_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr     <= '0;
      r_lim_act <= RST_LIM;
      r_lim_shd <= RST_LIM;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_hz      <= 1'b0;
    end else begin
      if (i_sync)    r_ctr <= '0;
      else if (i_en) r_ctr <= w_wrap ? '0 : r_ctr + 1'b1;
      r_tick <= w_wrap;
      if (i_sync)      r_hz <= 1'b0;
      else if (i_mode) r_hz <= w_wrap;
      else if (w_wrap) r_hz <= ~r_hz;
      if (w_apply) r_lim_act <= r_lim_shd;
      if (i_load)  r_lim_shd <= i_lim;
      // A load landing on an application point stays pending for the next one.
      if (i_load)       r_pend <= 1'b1;
      else if (w_apply) r_pend <= 1'b0;
    end
  end

  assign o_tick = r_tick;
  assign o_hz   = r_hz;
  assign o_pend = r_pend;
endmodule

module clkdiv_bank #(
  parameter int                BITLEN  = 8,
  parameter int                NCH     = 4,
  parameter logic [BITLEN-1:0] RST_LIM = {BITLEN{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        en,
  input  logic [NCH-1:0]        mode,
  input  logic [NCH*BITLEN-1:0] lim_in,
  input  logic [NCH-1:0]        lim_load,
  input  logic                  sync,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0]        hzX,
  output logic [NCH-1:0]        pend
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkdiv_ch #(.BITLEN(BITLEN), .RST_LIM(RST_LIM)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en[i]),
      .i_mode (mode[i]),
      .i_lim  (lim_in[i*BITLEN +: BITLEN]),
      .i_load (lim_load[i]),
      .i_sync (sync),
      .o_tick (tick[i]),
      .o_hz   (hzX[i]),
      .o_pend (pend[i])
    );
  end
endmodule

// File: tb/tb_clkdiv_bank.sv
// Bench for clkdiv_bank: a hand-derived vector table, then directed and random
// sequences checked against a per-channel reference model through a queue.
module tb_clkdiv_bank;
  localparam int BL = 8;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] en, mode, lim_load;
  logic [NC*BL-1:0] lim_in;
  logic          sync;
  logic [NC-1:0] tick, hzX, pend;

  clkdiv_bank #(.BITLEN(BL), .NCH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .lim_in(lim_in),
    .lim_load(lim_load), .sync(sync), .tick(tick), .hzX(hzX), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en, mode, load;
    logic [7:0] lim0;
    logic       sync;
    logic [3:0] tick, hz, pend;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] tick, hz, pend;
  } exp_t;

  vec_t tbl[14];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_ctr[NC], m_act[NC], m_shd[NC];
  logic [3:0] m_pend, m_tick, m_hz;

  function automatic vec_t mk(logic [3:0] e, m, l, logic [7:0] lim, logic s,
                              logic [3:0] t, h, p);
    vec_t v;
    v.en = e; v.mode = m; v.load = l; v.lim0 = lim; v.sync = s;
    v.tick = t; v.hz = h; v.pend = p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_ctr[i] = 8'd0; m_act[i] = 8'hFF; m_shd[i] = 8'hFF;
    end
    m_pend = '0; m_tick = '0; m_hz = '0;
  endtask

  // Reference behaviour of one clock edge, from the pre-edge state and inputs.
  task automatic model_step();
    for (int i = 0; i < NC; i++) begin
      logic w, a;
      w = en[i] && !sync && (m_ctr[i] == m_act[i]);
      a = m_pend[i] && (sync || !en[i] || w);
      m_tick[i] = w;
      if (sync) begin
        m_ctr[i] = 8'd0;
        m_hz[i]  = 1'b0;
      end else begin
        if (en[i]) m_ctr[i] = w ? 8'd0 : m_ctr[i] + 8'd1;
        if (mode[i]) m_hz[i] = w;
        else if (w)  m_hz[i] = !m_hz[i];
      end
      if (a) m_act[i] = m_shd[i];
      if (lim_load[i]) m_shd[i] = lim_in[i*BL +: BL];
      if (lim_load[i]) m_pend[i] = 1'b1;
      else if (a)      m_pend[i] = 1'b0;
    end
  endtask

  task automatic step(input string nm, input bit use_tbl, input logic [3:0] et, eh, ep);
    exp_t e;
    model_step();
    e.name = nm;
    if (use_tbl) begin e.tick = et; e.hz = eh; e.pend = ep; end
    else begin e.tick = m_tick; e.hz = m_hz; e.pend = m_pend; end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".tick"}, {4'h0, tick}, {4'h0, e.tick});
      chk({e.name, ".hzX"},  {4'h0, hzX},  {4'h0, e.hz});
      chk({e.name, ".pend"}, {4'h0, pend}, {4'h0, e.pend});
    end
    lim_load = '0;
    sync     = 1'b0;
  endtask

  task automatic run(input string nm, input int n);
    for (int k = 0; k < n; k++) step(nm, 1'b0, '0, '0, '0);
  endtask

  task automatic run_until(input string nm, input int ch, input logic [7:0] val);
    int k;
    k = 0;
    while (m_ctr[ch] != val && k < 50) begin
      step(nm, 1'b0, '0, '0, '0);
      k++;
    end
    if (m_ctr[ch] != val) begin
      checks++; errors++;
      $display("FAIL %s: ctr never reached %0d", nm, val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = '0; mode = '0; lim_load = '0; lim_in = '0; sync = 1'b0;
    model_reset();
    #12;
    chk("reset.tick", {4'h0, tick}, 8'h00);
    chk("reset.hzX",  {4'h0, hzX},  8'h00);
    chk("reset.pend", {4'h0, pend}, 8'h00);
    chk("reset.lim_act0", dut.g_ch[0].u_ch.r_lim_act, 8'hFF);
    rst_n = 1'b1;

    // ch0: load 3 while idle, then square mode: tick every 4, hzX period 8.
    tbl[0]  = mk(4'h0, 4'h0, 4'h1, 8'd3, 1'b0, 4'h0, 4'h0, 4'h1);
    tbl[1]  = mk(4'h0, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[2]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[3]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[4]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h1, 4'h1, 4'h0);
    tbl[6]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h1, 4'h0);
    tbl[7]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h1, 4'h0);
    tbl[8]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h1, 4'h0);
    tbl[9]  = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h1, 4'h0, 4'h0);
    tbl[10] = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[11] = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[12] = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[13] = mk(4'h1, 4'h0, 4'h0, 8'd0, 1'b0, 4'h1, 4'h1, 4'h0);
    for (int r = 0; r < 14; r++) begin
      en = tbl[r].en; mode = tbl[r].mode; lim_load = tbl[r].load;
      lim_in = {24'h0, tbl[r].lim0}; sync = tbl[r].sync;
      step($sformatf("tbl%0d", r), 1'b1, tbl[r].tick, tbl[r].hz, tbl[r].pend);
    end

    // ch1 lim=0: pulse mode holds tick/hzX high, then square toggles every cycle.
    lim_in = '0; lim_load = 4'b0010;
    step("c1_load", 1'b0, '0, '0, '0);
    step("c1_apply", 1'b0, '0, '0, '0);
    en = 4'b0011; mode = 4'b0010;
    run("c1_pulse", 6);
    mode = 4'b0000;
    run("c1_square", 6);

    // ch2 lim=5, reload 2 mid-period at ctr=1.
    lim_in = 32'h0005_0000; lim_load = 4'b0100;
    step("c2_load5", 1'b0, '0, '0, '0);
    step("c2_apply5", 1'b0, '0, '0, '0);
    en = 4'b0111;
    run("c2_run", 3);
    run_until("c2_seek", 2, 8'd1);
    lim_in = 32'h0002_0000; lim_load = 4'b0100;
    step("c2_load2", 1'b0, '0, '0, '0);
    run("c2_after", 16);

    // All channels at distinct limits, then a sync at arbitrary phase.
    lim_in = 32'h0604_0103; lim_load = 4'b1111;
    step("sy_load", 1'b0, '0, '0, '0);
    en = 4'b1111; mode = 4'b0101;
    run("sy_pre", 9);
    sync = 1'b1;
    step("sy_edge", 1'b0, '0, '0, '0);
    chk("sy_zero", {tick, hzX}, 8'h00);
    run("sy_post", 16);

    // ch3 lim=4: pause at ctr=2 for 10 cycles, then resume.
    lim_in = 32'h0400_0000; lim_load = 4'b1000;
    step("c3_load", 1'b0, '0, '0, '0);
    run("c3_run", 7);
    run_until("c3_seek", 3, 8'd2);
    en[3] = 1'b0;
    run("c3_hold", 10);
    chk("c3_ctr_hold", dut.g_ch[3].u_ch.r_ctr, 8'd2);
    en[3] = 1'b1;
    run("c3_resume", 8);

    for (int k = 0; k < 300; k++) begin
      en   = 4'($urandom);
      mode = 4'($urandom);
      for (int i = 0; i < NC; i++) lim_in[i*BL +: BL] = 8'($urandom_range(0, 6));
      lim_load = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      sync     = ($urandom_range(0, 40) == 0);
      step("rand", 1'b0, '0, '0, '0);
    end

    // Asynchronous reset between edges with pending loads in flight.
    en = 4'b1111; mode = 4'b0000; lim_load = 4'b1111; lim_in = 32'h0302_0105;
    step("pre_rst", 1'b0, '0, '0, '0);
    chk("pre_rst.pend", {4'h0, pend}, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.tick", {4'h0, tick}, 8'h00);
    chk("arst.hzX",  {4'h0, hzX},  8'h00);
    chk("arst.pend", {4'h0, pend}, 8'h00);
    chk("arst.lim_act0", dut.g_ch[0].u_ch.r_lim_act, 8'hFF);
    chk("arst.lim_act3", dut.g_ch[3].u_ch.r_lim_act, 8'hFF);
    model_reset();
    #2;
    rst_n = 1'b1;
    lim_in = 32'h0201_0002; lim_load = 4'b1111; en = 4'b0000;
    step("post_load", 1'b0, '0, '0, '0);
    step("post_apply", 1'b0, '0, '0, '0);
    en = 4'b1111; mode = 4'b1010;
    run("post_run", 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter BITLEN, default 8, meaning counter and limit width in bits.
REQ-002 SHALL have parameter NCH, default 4, meaning number of independent divider channels.
REQ-003 SHALL have parameter RST_LIM, default all-ones (BITLEN bits), meaning the active and shadow limit value after reset.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port en  input  NCH  meaning per-channel count enable.
REQ-007 SHALL have port mode  input  NCH  meaning per-channel output mode: 0 = square (toggle on wrap), 1 = one-cycle pulse on wrap.
REQ-008 SHALL have port lim_in  input  NCH*BITLEN  meaning new limits; channel i uses bits [i*BITLEN +: BITLEN].
REQ-009 SHALL have port lim_load  input  NCH  meaning per-channel strobe that captures its lim_in slice into the shadow limit.
REQ-010 SHALL have port sync  input  1  meaning restart of all channels in phase.
REQ-011 SHALL have port tick  output  NCH  meaning registered one-cycle wrap strobe per channel.
REQ-012 SHALL have port hzX  output  NCH  meaning registered divided output per channel.
REQ-013 SHALL have port pend  output  NCH  meaning a shadow limit is waiting to be applied.

Function
REQ-014 Each channel SHALL hold ctr (BITLEN), lim_act, lim_shd, pend, tick and hzX registers; channels SHALL be fully independent except for sync.
REQ-015 Wrap for channel i SHALL be defined as en[i]=1 and ctr==lim_act at a clk edge, with sync=0.
REQ-016 With en[i]=1 and no wrap, ctr SHALL increment by 1; on wrap, ctr SHALL load 0; no other wrap-around point exists.
REQ-017 tick[i] SHALL be 1 in the cycle after a wrap edge and 0 otherwise, giving one tick per lim_act+1 enabled cycles.
REQ-018 With mode[i]=0, hzX[i] SHALL invert on each wrap edge (period 2*(lim_act+1) cycles); with mode[i]=1, hzX[i] SHALL equal the registered wrap strobe (identical to tick[i]).
REQ-019 mode SHALL be sampled every edge; a change takes effect from the next edge with no glitch on the outputs.
REQ-020 With en[i]=0, ctr, lim_act and hzX SHALL hold; tick SHALL be 0; in mode 1, hzX SHALL be 0.
REQ-021 lim_act=0 SHALL give tick=1 every enabled cycle and, in mode 0, hzX toggling every cycle.
REQ-022 lim_load[i]=1 SHALL write lim_in slice i to lim_shd and set pend[i]=1; a later load before application overwrites lim_shd.
REQ-023 A pending shadow SHALL be copied to lim_act and pend cleared on the next wrap edge, or on the next edge where en[i]=0, or on a sync edge.
REQ-024 If lim_load and wrap coincide, the wrap SHALL use the old lim_act, the new value SHALL enter lim_shd and pend SHALL remain 1 until the following application point.
REQ-025 sync=1 SHALL, on that edge, set every ctr, tick and hzX to 0 and apply pending shadows; sync SHALL take precedence over en and wrap.
REQ-026 All outputs SHALL be driven directly from flops; no derived clock SHALL be generated or used.

Reset
REQ-027 rst_n=0 SHALL asynchronously set ctr=0, tick=0, hzX=0, pend=0, lim_act=lim_shd=RST_LIM for all channels.
REQ-028 Reset asserted mid-count SHALL take effect immediately, without waiting for clk; counting SHALL resume on the first clk edge after rst_n rises with en high.

Verification
REQ-029 Reset, load lim=3 into ch0 with en=0, then en[0]=1, mode 0 -> pend clears one edge after load, tick pulses every 4 cycles, hzX period 8 cycles, 50% duty.
REQ-030 ch1 lim=0, en=1, mode 1 -> tick[1] and hzX[1] held 1 every cycle; switch to mode 0 -> hzX[1] toggles every cycle.
REQ-031 ch2 running lim=5; load 2 when ctr=1 -> pend=1, current period still 6 cycles, then 3-cycle periods, pend=0 after that wrap.
REQ-032 All channels running at different limits, assert sync one cycle at arbitrary counts -> next cycle all ctr=0, tick=0, hzX=0; each channel's first tick occurs lim_act+1 cycles later, aligned.
REQ-033 Drive rst_n low between clk edges mid-count -> outputs 0 and pend 0 immediately; lim_act reads RST_LIM (255 for BITLEN=8).
REQ-034 ch3 lim=4, drop en[3] at ctr=2 for 10 cycles -> ctr holds 2, tick 0, hzX holds; on re-enable next tick after 3 more cycles.
